// File: rtl/scan_sequencer.sv
// scan_sequencer: turns decoded tester commands into cycle-accurate CSOC clock/reset/scan pin activity.
// Optional SCAN_SEQ_RESTORE_EN: GET_STATE recirculates scan_out into scan_in so the chain is restored.
module scan_sequencer #(
  parameter int HALF_PERIOD = 2,
  parameter int RST_PULSES = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready,
  output logic             part_clk,
  output logic             part_rstn,
  output logic             part_test_se,
  output logic             part_test_tm,
  output logic             part_scan_in,
  input  logic             part_scan_out,
  output logic             busy,
  output logic             err,
  output logic [31:0]      pulse_cnt
);
  localparam int PW = $clog2(2 * HALF_PERIOD) + 1;
  localparam logic [PW-1:0] PH_LAST = PW'(2 * HALF_PERIOD - 1);
  localparam logic [PW-1:0] PH_HI = PW'(HALF_PERIOD);
  typedef enum logic [3:0] {IDLE, RST_PULSE, SET_WAIT, SET_PULSE, GET_PRES, GET_PULSE, EXEC, FREE, DONE} state_t;
  state_t state, state_n;
  logic [PW-1:0] ph, ph_n;
  logic [CNT_W-1:0] rem, rem_n;
  logic stop, accept, pulsing, ph_end, clk_n, load_get;
  assign accept = cmd_valid && cmd_ready;
  assign pulsing = (state inside {RST_PULSE, SET_PULSE, GET_PULSE, FREE}) || (state == EXEC && rem != '0);
  assign ph_end = pulsing && ph == PH_LAST;
  assign ph_n = (pulsing && !ph_end) ? ph + PW'(1) : '0;
  assign rem_n = (state == IDLE && accept) ? (cmd_op == 3'd0 ? CNT_W'(RST_PULSES) : cmd_count)
               : (ph_end && state != FREE) ? rem - CNT_W'(1) : rem;
  // part_clk is decoded from state/phase, so its next value tells us when a rising edge is issued
  assign clk_n = ph_n < PH_HI && ((state_n inside {RST_PULSE, SET_PULSE, GET_PULSE, FREE}) || (state_n == EXEC && rem_n != '0));
  assign load_get = state_n == GET_PRES && state != GET_PRES && rem_n != '0;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:
        if (accept)
          state_n = cmd_op == 3'd0 ? RST_PULSE : cmd_op == 3'd1 ? SET_WAIT : cmd_op == 3'd2 ? GET_PRES
                  : cmd_op == 3'd3 ? EXEC : cmd_op == 3'd4 ? FREE : IDLE;
      RST_PULSE, EXEC: state_n = (rem == '0 || (ph_end && rem == CNT_W'(1))) ? DONE : state;
      SET_WAIT: state_n = rem == '0 ? DONE : in_valid ? SET_PULSE : SET_WAIT;
      SET_PULSE: state_n = !ph_end ? SET_PULSE : rem == CNT_W'(1) ? DONE : SET_WAIT;
      GET_PRES: state_n = rem == '0 ? DONE : out_ready ? GET_PULSE : GET_PRES;
      GET_PULSE: state_n = !ph_end ? GET_PULSE : rem == CNT_W'(1) ? DONE : GET_PRES;
      FREE: state_n = (ph_end && (stop || accept)) ? DONE : FREE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ph <= '0;
      rem <= '0;
      stop <= 1'b0;
      err <= 1'b0;
      part_scan_in <= 1'b0;
      out_data <= 8'h30;
      pulse_cnt <= '0;
    end else begin
      ph <= ph_n;
      rem <= rem_n;
      stop <= state == FREE && (stop || accept);
      if (!part_clk && clk_n) pulse_cnt <= pulse_cnt + 32'd1;
      if (accept) err <= 1'b0;
      else if (in_ready && in_valid && in_data != 8'h30 && in_data != 8'h31) err <= 1'b1;
      if (in_ready && in_valid) part_scan_in <= in_data == 8'h31;
      if (state == IDLE && accept && cmd_op == 3'd0) part_scan_in <= 1'b0;
      if (load_get) begin
        out_data <= part_scan_out ? 8'h31 : 8'h30;
`ifdef SCAN_SEQ_RESTORE_EN
        part_scan_in <= part_scan_out;
`else
        part_scan_in <= 1'b0;
`endif
      end
    end
  end
  always_comb begin
    part_clk = pulsing && ph < PH_HI;
    part_rstn = state != RST_PULSE;
    part_test_tm = state inside {SET_WAIT, SET_PULSE, GET_PRES, GET_PULSE};
    part_test_se = state inside {SET_WAIT, SET_PULSE, GET_PRES, GET_PULSE};
    cmd_ready = state == IDLE || (state == FREE && cmd_op == 3'd5);
    in_ready = state == SET_WAIT && rem != '0;
    out_valid = state == GET_PRES && rem != '0;
    busy = state != IDLE;
  end
endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: scoreboard bench; expected scan bits/bytes are queued as stimulus is driven and checked as pins move.
module tb_scan_sequencer;
  localparam int HP = 2;
  localparam int RP = 4;
  logic clk = 0, rst = 1, cmd_valid = 0, in_valid = 0, out_ready = 0;
  logic [2:0] cmd_op = 0;
  logic [15:0] cmd_count = 0;
  logic [7:0] in_data = 0;
  logic cmd_ready, in_ready, out_valid, part_clk, part_rstn, part_test_se, part_test_tm, part_scan_in, part_scan_out, busy, err;
  logic [7:0] out_data;
  logic [31:0] pulse_cnt;
  int vectors = 0, miscompares = 0;
  int exp_pcnt = 0;
  logic exp_q[$];
  logic [7:0] out_q[$];
  logic exp_se = 0, exp_tm = 0, mon_en = 0, pclk_d = 0;
  int hi_len = 0;
  int rises = 0, get_base = 1000000;
  logic [5:0] chain_bits = 6'b101100;

  scan_sequencer #(.HALF_PERIOD(HP), .RST_PULSES(RP), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_count(cmd_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .part_clk(part_clk), .part_rstn(part_rstn), .part_test_se(part_test_se),
    .part_test_tm(part_test_tm), .part_scan_in(part_scan_in), .part_scan_out(part_scan_out), .busy(busy),
    .err(err), .pulse_cnt(pulse_cnt));

  always #5 clk = ~clk;

  function automatic logic chain_bit(input int i);
    return (i >= 0 && i < 6) ? chain_bits[5-i] : 1'b0;
  endfunction

  always @(posedge part_clk) rises <= rises + 1;
  assign part_scan_out = chain_bit(rises - get_base);

  always @(negedge clk) begin
    logic e;
    if (mon_en && part_clk && !pclk_d) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL extra_pulse: got unexpected part_clk rise at %0t, want none", $time);
      end else begin
        e = exp_q.pop_front();
        if (part_scan_in !== e || part_test_se !== exp_se || part_test_tm !== exp_tm) begin
          miscompares++;
          $display("FAIL pulse_pins: got si=%b se=%b tm=%b, want si=%b se=%b tm=%b", part_scan_in, part_test_se, part_test_tm, e, exp_se, exp_tm);
        end
      end
    end
    if (part_clk) hi_len++;
    else if (pclk_d) begin
      if (mon_en) begin
        vectors++;
        if (hi_len != HP) begin
          miscompares++;
          $display("FAIL pulse_width: got %0d, want %0d", hi_len, HP);
        end
      end
      hi_len = 0;
    end
    pclk_d = part_clk;
  end

  task automatic apply_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    exp_pcnt = 0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] n);
    int t = 0;
    cmd_op = op;
    cmd_count = n;
    #1;
    while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) begin
      vectors++; miscompares++;
      $display("FAIL issue_timeout: got cmd_ready=0, want 1 for op %0d", op);
    end
    cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) begin
      vectors++; miscompares++;
      $display("FAIL idle_timeout: got busy=1, want 0");
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) begin
      vectors++; miscompares++;
      $display("FAIL in_ready_timeout: got 0, want 1");
    end
    in_valid = 1;
    in_data = b;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic check_end(input string name);
    vectors++;
    if (exp_q.size() != 0 || pulse_cnt !== 32'(exp_pcnt)) begin
      miscompares++;
      $display("FAIL %s_end: got pending=%0d pulse_cnt=%0d, want pending=0 pulse_cnt=%0d", name, exp_q.size(), pulse_cnt, exp_pcnt);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if ({part_clk, part_rstn, part_test_se, part_test_tm, part_scan_in} !== 5'b01000) begin
      miscompares++;
      $display("FAIL reset_pins: got %b, want 01000", {part_clk, part_rstn, part_test_se, part_test_tm, part_scan_in});
    end
    vectors++;
    if ({out_valid, in_ready, busy, err, cmd_ready} !== 5'b00001 || out_data !== 8'h30 || pulse_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got ov=%b ir=%b busy=%b err=%b cr=%b od=%h pc=%0d, want 0 0 0 0 1 30 0", out_valid, in_ready, busy, err, cmd_ready, out_data, pulse_cnt);
    end
  endtask

  task automatic test_set_state();
    logic [7:0] bytes [6] = '{8'h31, 8'h31, 8'h30, 8'h30, 8'h31, 8'h30};
    mon_en = 1; exp_se = 1; exp_tm = 1;
    issue(3'd1, 16'd6);
    vectors++;
    if (part_test_se !== 1'b1 || part_test_tm !== 1'b1) begin
      miscompares++;
      $display("FAIL set_mode: got se=%b tm=%b, want 1 1", part_test_se, part_test_tm);
    end
    foreach (bytes[i]) begin
      exp_q.push_back(bytes[i] == 8'h31);
      send_byte(bytes[i]);
    end
    exp_pcnt += 6;
    wait_idle();
    check_end("set");
    vectors++;
    if (err !== 1'b0 || part_test_se !== 1'b0) begin
      miscompares++;
      $display("FAIL set_after: got err=%b se=%b, want 0 0", err, part_test_se);
    end
  endtask

  task automatic test_set_err();
    issue(3'd1, 16'd2);
    exp_q.push_back(1'b0);
    send_byte(8'h78);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL set_err_flag: got %b, want 1", err);
    end
    exp_q.push_back(1'b1);
    send_byte(8'h31);
    exp_pcnt += 2;
    wait_idle();
    check_end("set_err");
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL set_err_sticky: got %b, want 1", err);
    end
  endtask

  task automatic test_get_state();
    int t;
    logic [7:0] e;
    get_base = rises;
    for (int i = 0; i < 6; i++) begin
      out_q.push_back(chain_bit(i) ? 8'h31 : 8'h30);
`ifdef SCAN_SEQ_RESTORE_EN
      exp_q.push_back(chain_bit(i));
`else
      exp_q.push_back(1'b0);
`endif
    end
    issue(3'd2, 16'd6);
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear: got %b, want 0", err);
    end
    for (int i = 0; i < 6; i++) begin
      t = 0;
      while (!out_valid && t < 200) begin @(negedge clk); t++; end
      e = out_q.pop_front();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== e) begin
        miscompares++;
        $display("FAIL get_byte%0d: got valid=%b data=%h, want 1 %h", i, out_valid, out_data, e);
      end
      repeat (10) @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || part_clk !== 1'b0 || pulse_cnt !== 32'(exp_pcnt)) begin
        miscompares++;
        $display("FAIL get_stall%0d: got valid=%b pclk=%b pc=%0d, want 1 0 %0d", i, out_valid, part_clk, pulse_cnt, exp_pcnt);
      end
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      exp_pcnt++;
    end
    wait_idle();
    check_end("get");
    get_base = 1000000;
  endtask

  task automatic test_execute();
    int t = 0;
    exp_se = 0; exp_tm = 0;
    issue(3'd3, 16'd0);
    while (busy && t < 10) begin t++; @(negedge clk); end
    vectors++;
    if (t != 2) begin
      miscompares++;
      $display("FAIL exec0_busy: got %0d cycles, want 2", t);
    end
    check_end("exec0");
    repeat (4) exp_q.push_back(1'b0);
    issue(3'd3, 16'd4);
    exp_pcnt += 4;
    wait_idle();
    check_end("exec4");
  endtask

  task automatic test_part_reset();
    repeat (RP) exp_q.push_back(1'b0);
    issue(3'd0, 16'd0);
    vectors++;
    if (part_rstn !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_low: got %b, want 0", part_rstn);
    end
    exp_pcnt += RP;
    wait_idle();
    check_end("part_reset");
    vectors++;
    if (part_rstn !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_high: got %b, want 1", part_rstn);
    end
  endtask

  task automatic test_free_run();
    apply_reset();
    exp_pcnt = 37 / (2 * HP) + 1;
    repeat (exp_pcnt) exp_q.push_back(1'b0);
    issue(3'd4, 16'd0);
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (k == 1) begin cmd_op = 3'd3; cmd_valid = 1; end
      if (k >= 2 && k <= 5) begin
        vectors++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL free_exec_block: got cmd_ready=%b busy=%b, want 0 1", cmd_ready, busy);
        end
      end
      if (k == 6) cmd_valid = 0;
    end
    cmd_op = 3'd5;
    cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
    wait_idle();
    check_end("free");
    vectors++;
    if (part_clk !== 1'b0) begin
      miscompares++;
      $display("FAIL free_clk_low: got %b, want 0", part_clk);
    end
  endtask

  task automatic test_reset_mid();
    mon_en = 0;
    issue(3'd3, 16'd100);
    repeat (21) @(negedge clk);
    apply_reset();
    @(negedge clk);
    vectors++;
    if (part_clk !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || pulse_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mid: got pclk=%b busy=%b cr=%b pc=%0d, want 0 0 1 0", part_clk, busy, cmd_ready, pulse_cnt);
    end
    repeat (8) @(negedge clk);
    vectors++;
    if (part_clk !== 1'b0 || pulse_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mid_hold: got pclk=%b pc=%0d, want 0 0", part_clk, pulse_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_set_state();
    test_set_err();
    test_get_state();
    test_execute();
    test_part_reset();
    test_free_run();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
